// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: mem_op codes,
// FSM state encodings, wait-counter width and small decode helpers.
package dmem_resp_pkg;

    localparam int DMEM_WAIT_W = 4;

    // mem_op codes presented by the MEM stage
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    // DMEM FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True when a half/word op carries low address bits that break alignment.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: mis = lo[0];
            MEM_LW, MEM_SW:          mis = |lo;
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Select the addressed byte/half of a word and sign- or zero-extend it.
    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] lo,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  r = {{24{b[7]}}, b};
            MEM_LBU: r = {24'd0, b};
            MEM_LH:  r = {{16{h[15]}}, h};
            MEM_LHU: r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word array: 4-bit byte-lane write enable,
// registered read of the addressed word whenever the port is enabled.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // Byte-lane write and registered read of the same word.
    // NOTE: the storage array and its read register have no reset; clearing a RAM
    // is not possible in one cycle, and the responder masks rdata outside ack.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: slave end of the MEM-stage load/store interface.
// Accepts one request at a time, inserts WAIT_CYCLES wait states, performs
// byte/half/word accesses and returns a one-cycle ack with optional error.
// Build option: define DMEM_MISALIGN_CHK_EN to flag misaligned half/word
// accesses as errors; otherwise the low address bits are masked.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            op_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  stallreq_o
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_W-1:0]       DEPTH_IDX = IDX_W'(DEPTH_WORDS);
    localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT = DMEM_WAIT_W'(WAIT_CYCLES);

    logic [1:0]             state_q, state_d;
    logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [3:0]             op_q, op_d;
    logic                   err_q, err_d;

    logic                   fire;      // perform the array access on this edge
    logic                   from_in;   // zero-wait access: use the live inputs
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   sel_we;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [3:0]             sel_op;
    logic                   acc_err;
    logic [3:0]             lane_we;
    logic [DATA_WIDTH-1:0]  lane_wdata;
    logic [DATA_WIDTH-1:0]  arr_rdata;

    // FSM next state, request latching and access timing.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        fire    = 1'b0;
        from_in = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    op_d    = op_i;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        fire    = 1'b1;
                        from_in = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    fire    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel_addr  = from_in ? addr_i  : addr_q;
    assign sel_we    = from_in ? we_i    : we_q;
    assign sel_wdata = from_in ? wdata_i : wdata_q;
    assign sel_op    = from_in ? op_i    : op_q;

    // Access decode: opcode/direction check, range check, byte-lane steering.
    always_comb begin
        acc_err    = 1'b0;
        lane_we    = 4'b0000;
        lane_wdata = sel_wdata;
        case (sel_op)
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: acc_err = sel_we;
            MEM_SB: begin
                acc_err    = !sel_we;
                lane_we    = 4'b0001 << sel_addr[1:0];
                lane_wdata = {4{sel_wdata[7:0]}};
            end
            MEM_SH: begin
                acc_err    = !sel_we;
                lane_we    = sel_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{sel_wdata[15:0]}};
            end
            MEM_SW: begin
                acc_err = !sel_we;
                lane_we = 4'b1111;
            end
            default: acc_err = 1'b1;
        endcase
        if (sel_addr[ADDR_WIDTH-1:2] >= DEPTH_IDX) begin
            acc_err = 1'b1;
        end
`ifdef DMEM_MISALIGN_CHK_EN
        if (is_misaligned(sel_op, sel_addr[1:0])) begin
            acc_err = 1'b1;
        end
`endif
        if (acc_err) begin
            lane_we = 4'b0000;
        end
    end

    // Error status captured on the access edge, held through RESP.
    assign err_d = fire ? acc_err : err_q;

    // State and latched request fields.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            op_q    <= MEM_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (MEM_AW),
        .DW    (DATA_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (fire && !acc_err),
        .be_i    (lane_we),
        .addr_i  (sel_addr[MEM_AW+1:2]),
        .wdata_i (lane_wdata),
        .rdata_o (arr_rdata)
    );

    assign ack_o      = (state_q == ST_RESP);
    assign err_o      = ack_o && err_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign stallreq_o = ((state_q == ST_IDLE) && req_i) || (state_q == ST_WAIT);
    assign rdata_o    = (ack_o && !err_q && !we_q) ? load_extend(op_q, addr_q[1:0], arr_rdata)
                                                   : '0;

endmodule
